// File: rtl/w5300_pkg.sv
// w5300_pkg
//   Shared definitions for the W5300 UDP socket multiplexer: socket register
//   map offsets, command register codes, error codes, caddr field positions
//   and the controller FSM state encoding.
package w5300_pkg;

   // Socket n register block starts at SOCK_BASE + (n << SOCK_SHIFT)
   localparam logic [9:0] SOCK_BASE  = 10'h200;
   localparam int         SOCK_SHIFT = 6;

   // Socket register offsets (word addresses within the socket block)
   localparam logic [9:0] OFF_CR       = 10'h02;
   localparam logic [9:0] OFF_DPORTR   = 10'h12;
   localparam logic [9:0] OFF_DIPR0    = 10'h14;
   localparam logic [9:0] OFF_DIPR1    = 10'h16;
   localparam logic [9:0] OFF_WRSR0    = 10'h20;
   localparam logic [9:0] OFF_WRSR1    = 10'h22;
   localparam logic [9:0] OFF_TX_FSR0  = 10'h24;
   localparam logic [9:0] OFF_TX_FSR1  = 10'h26;
   localparam logic [9:0] OFF_RX_RSR0  = 10'h28;
   localparam logic [9:0] OFF_RX_RSR1  = 10'h2A;
   localparam logic [9:0] OFF_TX_FIFOR = 10'h2E;
   localparam logic [9:0] OFF_RX_FIFOR = 10'h30;

   // Command register codes
   localparam logic [15:0] CR_SEND = 16'h0020;
   localparam logic [15:0] CR_RECV = 16'h0040;

   // Sticky error codes
   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_TX_OVF = 3'd4;
   localparam logic [2:0] ERR_RX_OVF = 3'd5;

   // caddr = {valid_n, rd, addr[9:0]}
   localparam int          CADDR_VALID_N = 11;
   localparam int          CADDR_RD      = 10;
   localparam int          CADDR_AW      = 10;
   localparam logic [11:0] CADDR_IDLE    = 12'hC00;

   typedef enum logic [4:0] {
      IDLE, ARB,
      TX_FSR0, TX_FSR1, TX_CHK, DIPR0, DIPR1, DPORT, TX_FIFO, TX_INC,
      WRSR0, WRSR1, TX_CMD,
      RX_RSR0, RX_RSR1, RX_CHK, RX_HDR, RX_FIFO, RX_CMD,
      DONE
   } state_t;

   // Number of 16-bit words needed to carry a byte count (rounded up)
   function automatic logic [16:0] words_of(input logic [15:0] bytes);
      return ({1'b0, bytes} + 17'd1) >> 1;
   endfunction

endpackage

// File: rtl/w5300_rr_arbiter.sv
// w5300_rr_arbiter
//   Combinational round-robin arbiter: grants the lowest requesting index at
//   or after ptr, wrapping modulo N_SOCK.
//   Ports: req   - request vector
//          ptr   - search start index
//          grant - granted index (0 when nothing requests)
//          valid - at least one request present
module w5300_rr_arbiter #(
   parameter int  N_SOCK = 2,
   localparam int SW     = (N_SOCK > 1) ? $clog2(N_SOCK) : 1
) (
   input  logic [N_SOCK-1:0] req,
   input  logic [SW-1:0]     ptr,
   output logic [SW-1:0]     grant,
   output logic              valid
);

   always_comb begin
      int          sum;
      logic [SW-1:0] idx;
      grant = '0;
      valid = 1'b0;
      sum   = 0;
      idx   = '0;
      // Walk from the farthest offset down so the nearest requester wins last
      for (int i = N_SOCK - 1; i >= 0; i--) begin
         sum = int'(ptr) + i;
         if (sum >= N_SOCK) sum = sum - N_SOCK;
         idx = SW'(sum);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/w5300_udp_mux.sv
// w5300_udp_mux
//   Serves N_SOCK W5300 UDP sockets over the W5300 host bus. Transmit
//   requests are granted round-robin; a pending interrupt takes priority and
//   drains one received packet from socket rx_ptr.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     init_done             chip/socket init complete; stay idle while low
//     tx_req/tx_ack         per-socket send request / completion pulse
//     dest_ip/port/tx_size  per-socket send parameters (latched on grant)
//     tx_data/tx_sock/tx_buffer_addr  external TX payload buffer port
//     rx_data/rx_valid/rx_buffer_addr/rx_sock/rx_size  received payload
//     busy, err_code        status; err_code is sticky
//     caddr/wr_data/rd_data/op_status  W5300 bus access handshake
//     int_n                 W5300 interrupt, active low
module w5300_udp_mux
   import w5300_pkg::*;
#(
   parameter int  N_SOCK = 2,
   parameter int  BUF_AW = 12,
   localparam int SW     = (N_SOCK > 1) ? $clog2(N_SOCK) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init_done,
   input  logic [N_SOCK-1:0]    tx_req,
   input  logic [32*N_SOCK-1:0] dest_ip,
   input  logic [16*N_SOCK-1:0] dest_port,
   input  logic [16*N_SOCK-1:0] tx_size,
   input  logic [15:0]          tx_data,
   output logic [SW-1:0]        tx_sock,
   output logic [BUF_AW-1:0]    tx_buffer_addr,
   output logic [N_SOCK-1:0]    tx_ack,
   output logic [15:0]          rx_data,
   output logic                 rx_valid,
   output logic [BUF_AW-1:0]    rx_buffer_addr,
   output logic [SW-1:0]        rx_sock,
   output logic [15:0]          rx_size,
   output logic                 busy,
   output logic [2:0]           err_code,
   input  logic                 op_status,
   input  logic [15:0]          rd_data,
   output logic [15:0]          wr_data,
   output logic [11:0]          caddr,
   input  logic                 int_n
);

   localparam logic [17:0] BUF_WORDS = 18'(1) << BUF_AW;

   state_t        state, state_nx;
   logic [SW-1:0] tx_ptr, rx_ptr;
   logic [SW-1:0] arb_grant;
   logic          arb_valid;
   logic          is_rx;
   logic [31:0]   ip_q;
   logic [15:0]   port_q;
   logic [15:0]   size_q;
   logic [16:0]   tx_words;
   logic [31:0]   fsr;
   logic [31:0]   rsr;
   logic [1:0]    hdr_cnt;
   logic [16:0]   rx_words;
   logic [16:0]   rx_cnt;

   // Fields of the socket the arbiter would grant this cycle
   logic [31:0]   g_ip;
   logic [15:0]   g_port, g_size;
   logic [16:0]   g_words;
   logic          g_too_big;
   logic          tx_last, rx_last;
   logic [SW-1:0] cur_sock;
   logic [9:0]    base;

   // Bus access decode
   logic          acc, rd;
   logic [9:0]    off;
   logic [15:0]   wdat;

   w5300_rr_arbiter #(.N_SOCK(N_SOCK)) u_arb (
      .req   (tx_req),
      .ptr   (tx_ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   function automatic logic [SW-1:0] inc_mod(input logic [SW-1:0] p);
      return (int'(p) == N_SOCK - 1) ? '0 : p + 1'b1;
   endfunction

   assign g_ip      = dest_ip[32*arb_grant +: 32];
   assign g_port    = dest_port[16*arb_grant +: 16];
   assign g_size    = tx_size[16*arb_grant +: 16];
   assign g_words   = words_of(g_size);
   assign g_too_big = ({1'b0, g_words} > BUF_WORDS);
   assign tx_last   = (17'(tx_buffer_addr) == tx_words - 17'd1);
   assign rx_last   = (rx_cnt == rx_words - 17'd1);
   assign cur_sock  = is_rx ? rx_sock : tx_sock;
   assign base      = SOCK_BASE + (10'(cur_sock) << SOCK_SHIFT);
   assign busy      = (state != IDLE);

   always_comb begin
      for (int i = 0; i < N_SOCK; i++)
         tx_ack[i] = (state == DONE) && !is_rx && (tx_sock == SW'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and bus access outputs. Access states hold caddr/wr_data
   // until op_status is seen, then advance on that same cycle.
   always_comb begin
      state_nx = state;
      acc      = 1'b0;
      rd       = 1'b0;
      off      = '0;
      wdat     = '0;
      unique case (state)
         IDLE:
            if (init_done && (!int_n || (|tx_req))) state_nx = ARB;
         ARB: begin
            if (!int_n)                          state_nx = RX_RSR0;
            else if (!arb_valid)                 state_nx = IDLE;
            else if (g_size == 16'd0 || g_too_big) state_nx = DONE;
            else                                 state_nx = TX_FSR0;
         end
         TX_FSR0: begin
            acc = 1'b1; rd = 1'b1; off = OFF_TX_FSR0;
            if (op_status) state_nx = TX_FSR1;
         end
         TX_FSR1: begin
            acc = 1'b1; rd = 1'b1; off = OFF_TX_FSR1;
            if (op_status) state_nx = TX_CHK;
         end
         TX_CHK:
            state_nx = (fsr < {16'h0, size_q}) ? TX_FSR0 : DIPR0;
         DIPR0: begin
            acc = 1'b1; off = OFF_DIPR0; wdat = ip_q[31:16];
            if (op_status) state_nx = DIPR1;
         end
         DIPR1: begin
            acc = 1'b1; off = OFF_DIPR1; wdat = ip_q[15:0];
            if (op_status) state_nx = DPORT;
         end
         DPORT: begin
            acc = 1'b1; off = OFF_DPORTR; wdat = port_q;
            if (op_status) state_nx = TX_FIFO;
         end
         TX_FIFO: begin
            acc = 1'b1; off = OFF_TX_FIFOR; wdat = tx_data;
            if (op_status) state_nx = tx_last ? WRSR0 : TX_INC;
         end
         // One idle cycle lets the external buffer present the next word
         TX_INC:
            state_nx = TX_FIFO;
         WRSR0: begin
            acc = 1'b1; off = OFF_WRSR0; wdat = 16'h0000;
            if (op_status) state_nx = WRSR1;
         end
         WRSR1: begin
            acc = 1'b1; off = OFF_WRSR1; wdat = size_q;
            if (op_status) state_nx = TX_CMD;
         end
         TX_CMD: begin
            acc = 1'b1; off = OFF_CR; wdat = CR_SEND;
            if (op_status) state_nx = DONE;
         end
         RX_RSR0: begin
            acc = 1'b1; rd = 1'b1; off = OFF_RX_RSR0;
            if (op_status) state_nx = RX_RSR1;
         end
         RX_RSR1: begin
            acc = 1'b1; rd = 1'b1; off = OFF_RX_RSR1;
            if (op_status) state_nx = RX_CHK;
         end
         RX_CHK:
            state_nx = (rsr == 32'h0) ? IDLE : RX_HDR;
         RX_HDR: begin
            acc = 1'b1; rd = 1'b1; off = OFF_RX_FIFOR;
            if (op_status && hdr_cnt == 2'd3)
               state_nx = (rd_data == 16'h0) ? RX_CMD : RX_FIFO;
         end
         RX_FIFO: begin
            acc = 1'b1; rd = 1'b1; off = OFF_RX_FIFOR;
            if (op_status && rx_last) state_nx = RX_CMD;
         end
         RX_CMD: begin
            acc = 1'b1; off = OFF_CR; wdat = CR_RECV;
            if (op_status) state_nx = DONE;
         end
         DONE:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase

      caddr   = CADDR_IDLE;
      wr_data = 16'h0000;
      if (acc) begin
         caddr[CADDR_VALID_N]    = 1'b0;
         caddr[CADDR_RD]         = rd;
         caddr[CADDR_AW-1:0]     = base + off;
         wr_data                 = wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_ptr         <= '0;
         rx_ptr         <= '0;
         is_rx          <= 1'b0;
         tx_sock        <= '0;
         rx_sock        <= '0;
         ip_q           <= '0;
         port_q         <= '0;
         size_q         <= '0;
         tx_words       <= '0;
         tx_buffer_addr <= '0;
         fsr            <= '0;
         rsr            <= '0;
         hdr_cnt        <= '0;
         rx_words       <= '0;
         rx_cnt         <= '0;
         rx_size        <= '0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         rx_buffer_addr <= '0;
         err_code       <= ERR_NONE;
      end else begin
         rx_valid <= 1'b0;
         unique case (state)
            ARB: begin
               if (!int_n) begin
                  is_rx   <= 1'b1;
                  rx_sock <= rx_ptr;
               end else if (arb_valid) begin
                  is_rx          <= 1'b0;
                  tx_sock        <= arb_grant;
                  ip_q           <= g_ip;
                  port_q         <= g_port;
                  size_q         <= g_size;
                  tx_words       <= g_words;
                  tx_buffer_addr <= '0;
                  if (g_size != 16'd0 && g_too_big) err_code <= ERR_TX_OVF;
               end
            end
            TX_FSR0: if (op_status) fsr[31:16] <= rd_data;
            TX_FSR1: if (op_status) fsr[15:0]  <= rd_data;
            TX_FIFO:
               if (op_status && !tx_last) tx_buffer_addr <= tx_buffer_addr + 1'b1;
            RX_RSR0: if (op_status) rsr[31:16] <= rd_data;
            RX_RSR1: if (op_status) rsr[15:0]  <= rd_data;
            RX_CHK: begin
               hdr_cnt <= '0;
               if (rsr == 32'h0) rx_ptr <= inc_mod(rx_ptr);
            end
            RX_HDR:
               if (op_status) begin
                  hdr_cnt <= hdr_cnt + 2'd1;
                  // Fourth header word carries the payload byte count
                  if (hdr_cnt == 2'd3) begin
                     rx_size  <= rd_data;
                     rx_words <= words_of(rd_data);
                     rx_cnt   <= '0;
                  end
               end
            RX_FIFO:
               if (op_status) begin
                  // Words past the buffer limit are drained but dropped
                  if ({1'b0, rx_cnt} < BUF_WORDS) begin
                     rx_valid       <= 1'b1;
                     rx_data        <= rd_data;
                     rx_buffer_addr <= BUF_AW'(rx_cnt);
                  end else begin
                     err_code <= ERR_RX_OVF;
                  end
                  rx_cnt <= rx_cnt + 17'd1;
               end
            DONE:
               if (is_rx) rx_ptr <= inc_mod(rx_ptr);
               else       tx_ptr <= inc_mod(tx_sock);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_w5300_udp_mux.sv
// tb_w5300_udp_mux
//   Directed bench for w5300_udp_mux with N_SOCK=2, BUF_AW=12. A small W5300
//   bus model answers accesses and logs them; monitors log acks and rx words.
module tb_w5300_udp_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_done = 1'b0;
   logic [1:0]  tx_req = '0;
   logic [63:0] dest_ip = '0;
   logic [31:0] dest_port = '0;
   logic [31:0] tx_size = '0;
   logic [15:0] tx_data = '0;
   logic [0:0]  tx_sock;
   logic [11:0] tx_buffer_addr;
   logic [1:0]  tx_ack;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic [11:0] rx_buffer_addr;
   logic [0:0]  rx_sock;
   logic [15:0] rx_size;
   logic        busy;
   logic [2:0]  err_code;
   logic        op_status = 1'b0;
   logic [15:0] rd_data = '0;
   logic [15:0] wr_data;
   logic [11:0] caddr;
   logic        int_n;

   int compared = 0;
   int mismatched = 0;

   // bus model state
   int          wait_cnt = 0;
   int          n_acc = 0;
   logic [10:0] log_ca [0:1023];
   logic [15:0] log_wd [0:1023];
   int          fsr_reads = 0;
   int          fsr_low_until = 0;
   logic [31:0] rsr_val = '0;
   logic [15:0] rx_mem [0:15];
   int          rx_rd_idx = 0;
   int          rx_base = 0;
   int          recv_cnt = 0;
   int          irq_arm = 0;

   // monitors
   int          low_cnt = 0;
   int          n_ack = 0;
   int          ack_log [0:255];
   int          n_rxv = 0;
   logic [15:0] rxv_data [0:255];
   logic [11:0] rxv_addr [0:255];

   assign int_n = (irq_arm > recv_cnt) ? 1'b0 : 1'b1;

   always #5 clk = ~clk;

   w5300_udp_mux #(.N_SOCK(2), .BUF_AW(12)) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done), .tx_req(tx_req),
      .dest_ip(dest_ip), .dest_port(dest_port), .tx_size(tx_size),
      .tx_data(tx_data), .tx_sock(tx_sock), .tx_buffer_addr(tx_buffer_addr),
      .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_buffer_addr(rx_buffer_addr), .rx_sock(rx_sock), .rx_size(rx_size),
      .busy(busy), .err_code(err_code), .op_status(op_status),
      .rd_data(rd_data), .wr_data(wr_data), .caddr(caddr), .int_n(int_n)
   );

   // W5300 bus model: answers each access two cycles after it appears
   always @(negedge clk) begin
      logic [15:0] rdv;
      rdv = 16'h0;
      if (op_status) begin
         op_status <= 1'b0;
         wait_cnt = 0;
      end else if (!caddr[11]) begin
         if (wait_cnt == 2) begin
            wait_cnt = 0;
            if (caddr[10]) begin
               case (caddr[5:0])
                  6'h26: begin
                     rdv = (fsr_reads < fsr_low_until) ? 16'd4 : 16'd100;
                     fsr_reads++;
                  end
                  6'h28: rdv = rsr_val[31:16];
                  6'h2A: rdv = rsr_val[15:0];
                  6'h30: begin
                     rdv = rx_mem[(rx_rd_idx - rx_base) & 15];
                     rx_rd_idx++;
                  end
                  default: rdv = 16'h0;
               endcase
            end else if (caddr[5:0] == 6'h02 && wr_data == 16'h0040) begin
               recv_cnt++;
            end
            if (n_acc < 1024) begin
               log_ca[n_acc] = caddr[10:0];
               log_wd[n_acc] = wr_data;
            end
            n_acc++;
            op_status <= 1'b1;
            rd_data   <= rdv;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      tx_data <= 16'hA000 + {7'b0, tx_sock, 8'h00} + {4'h0, tx_buffer_addr};
   end

   always @(negedge clk) begin
      if (!caddr[11]) low_cnt++;
      for (int s = 0; s < 2; s++)
         if (tx_ack[s]) begin
            ack_log[n_ack & 255] = s;
            n_ack++;
         end
      if (rx_valid) begin
         rxv_data[n_rxv & 255] = rx_data;
         rxv_addr[n_rxv & 255] = rx_buffer_addr;
         n_rxv++;
      end
   end

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++; if (caddr !== 12'hC00) begin mismatched++; $display("FAIL reset_caddr got %h want c00", caddr); end
      compared++; if (wr_data !== 16'h0) begin mismatched++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
      compared++; if (tx_ack !== 2'b00) begin mismatched++; $display("FAIL reset_tx_ack got %b want 00", tx_ack); end
      compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
      compared++; if (err_code !== 3'd0) begin mismatched++; $display("FAIL reset_err got %0d want 0", err_code); end
      compared++; if (tx_buffer_addr !== 12'h0 || rx_buffer_addr !== 12'h0) begin mismatched++; $display("FAIL reset_addr got %h/%h want 0/0", tx_buffer_addr, rx_buffer_addr); end
      compared++; if (rx_size !== 16'h0 || tx_sock !== 1'b0 || rx_sock !== 1'b0) begin mismatched++; $display("FAIL reset_rx_size_sock got %h/%b/%b want 0/0/0", rx_size, tx_sock, rx_sock); end
      rst_n = 1'b1;
      init_done = 1'b1;
      repeat (3) @(negedge clk);
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_round_robin;
      int got, k, a0;
      dest_ip = {32'h0A000002, 32'h0A000001};
      dest_port = {16'd2000, 16'd1000};
      tx_size = {16'd2, 16'd2};
      fsr_low_until = fsr_reads;
      a0 = n_ack; got = 0; k = 0;
      tx_req = 2'b11;
      while (got < 4 && k < 4000) begin
         @(negedge clk); k++;
         if (tx_ack != 2'b00) begin
            got++;
            if (got == 4) tx_req = 2'b00;
         end
      end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      compared++; if (n_ack - a0 !== 4) begin mismatched++; $display("FAIL rr_ack_count got %0d want 4", n_ack - a0); end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (ack_log[(a0 + i) & 255] !== (i % 2)) begin
            mismatched++; $display("FAIL rr_grant_%0d got %0d want %0d", i, ack_log[(a0 + i) & 255], i % 2);
         end
      end
   endtask

   task automatic test_tx_basic;
      logic [10:0] exp_ca [0:10];
      logic [15:0] exp_wd [0:10];
      int b, a0, k;
      exp_ca = '{11'h624, 11'h626, 11'h214, 11'h216, 11'h212, 11'h22E, 11'h22E, 11'h22E, 11'h220, 11'h222, 11'h202};
      exp_wd = '{16'h0, 16'h0, 16'hC0A8, 16'h0102, 16'h1234, 16'hA000, 16'hA001, 16'hA002, 16'h0, 16'h0006, 16'h0020};
      dest_ip[31:0] = 32'hC0A80102;
      dest_port[15:0] = 16'h1234;
      tx_size[15:0] = 16'd6;
      fsr_low_until = fsr_reads;
      b = n_acc; a0 = n_ack; k = 0;
      tx_req = 2'b01;
      while (tx_ack[0] !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      compared++; if (tx_ack[0] !== 1'b1) begin mismatched++; $display("FAIL basic_timeout got no ack want ack"); end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      compared++; if (n_acc - b !== 11) begin mismatched++; $display("FAIL basic_acc_count got %0d want 11", n_acc - b); end
      for (int i = 0; i < 11; i++) begin
         compared++;
         if (log_ca[b + i] !== exp_ca[i] || log_wd[b + i] !== exp_wd[i]) begin
            mismatched++; $display("FAIL basic_acc_%0d got %h/%h want %h/%h", i, log_ca[b + i], log_wd[b + i], exp_ca[i], exp_wd[i]);
         end
      end
      compared++; if (n_ack - a0 !== 1 || ack_log[a0 & 255] !== 0) begin mismatched++; $display("FAIL basic_ack got %0d pulses sock %0d want 1 sock 0", n_ack - a0, ack_log[a0 & 255]); end
      compared++; if (tx_buffer_addr !== 12'd2) begin mismatched++; $display("FAIL basic_last_addr got %0d want 2", tx_buffer_addr); end
   endtask

   task automatic test_fsr_poll;
      int b, a0, k, nf;
      tx_size[15:0] = 16'd10;
      fsr_low_until = fsr_reads + 3;
      b = n_acc; a0 = n_ack; k = 0;
      tx_req = 2'b01;
      while (tx_ack[0] !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      compared++; if (tx_ack[0] !== 1'b1) begin mismatched++; $display("FAIL poll_timeout got no ack want ack"); end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      nf = 0;
      for (int i = b; i < n_acc; i++) if (log_ca[i] == 11'h624) nf++;
      compared++; if (nf !== 4) begin mismatched++; $display("FAIL poll_fsr_pairs got %0d want 4", nf); end
      compared++; if (n_acc - b !== 19) begin mismatched++; $display("FAIL poll_acc_count got %0d want 19", n_acc - b); end
      compared++; if (log_ca[b + 8] !== 11'h214) begin mismatched++; $display("FAIL poll_first_write got %h want 214", log_ca[b + 8]); end
      compared++; if (n_ack - a0 !== 1) begin mismatched++; $display("FAIL poll_ack got %0d want 1", n_ack - a0); end
   endtask

   task automatic test_rx;
      logic [10:0] exp_ca [0:10];
      int b, a0, r0, k;
      exp_ca = '{11'h628, 11'h62A, 11'h630, 11'h630, 11'h630, 11'h630, 11'h630, 11'h630, 11'h630, 11'h202, 11'h624};
      rx_mem[0] = 16'hC0A8; rx_mem[1] = 16'h0105; rx_mem[2] = 16'h1388; rx_mem[3] = 16'h0005;
      rx_mem[4] = 16'h1111; rx_mem[5] = 16'h2222; rx_mem[6] = 16'h3333;
      rx_base = rx_rd_idx;
      rsr_val = 32'd9;
      tx_size[15:0] = 16'd2;
      fsr_low_until = fsr_reads;
      b = n_acc; a0 = n_ack; r0 = n_rxv; k = 0;
      irq_arm = recv_cnt + 1;
      tx_req = 2'b01;
      while (tx_ack[0] !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      compared++; if (tx_ack[0] !== 1'b1) begin mismatched++; $display("FAIL rx_timeout got no ack want ack"); end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         compared++;
         if (log_ca[b + i] !== exp_ca[i]) begin
            mismatched++; $display("FAIL rx_acc_%0d got %h want %h", i, log_ca[b + i], exp_ca[i]);
         end
      end
      compared++; if (log_wd[b + 9] !== 16'h0040) begin mismatched++; $display("FAIL rx_cr got %h want 0040", log_wd[b + 9]); end
      compared++; if (n_rxv - r0 !== 3) begin mismatched++; $display("FAIL rx_valid_count got %0d want 3", n_rxv - r0); end
      compared++;
      if (rxv_data[r0 & 255] !== 16'h1111 || rxv_data[(r0 + 1) & 255] !== 16'h2222 || rxv_data[(r0 + 2) & 255] !== 16'h3333) begin
         mismatched++; $display("FAIL rx_data got %h %h %h want 1111 2222 3333", rxv_data[r0 & 255], rxv_data[(r0 + 1) & 255], rxv_data[(r0 + 2) & 255]);
      end
      compared++;
      if (rxv_addr[r0 & 255] !== 12'd0 || rxv_addr[(r0 + 1) & 255] !== 12'd1 || rxv_addr[(r0 + 2) & 255] !== 12'd2) begin
         mismatched++; $display("FAIL rx_addr got %0d %0d %0d want 0 1 2", rxv_addr[r0 & 255], rxv_addr[(r0 + 1) & 255], rxv_addr[(r0 + 2) & 255]);
      end
      compared++; if (rx_size !== 16'd5) begin mismatched++; $display("FAIL rx_size got %0d want 5", rx_size); end
      compared++; if (n_ack - a0 !== 1) begin mismatched++; $display("FAIL rx_then_tx_ack got %0d want 1", n_ack - a0); end
   endtask

   task automatic test_zero_and_oversize;
      int l0, a0, k;
      tx_size[15:0] = 16'd0;
      l0 = low_cnt; a0 = n_ack; k = 0;
      tx_req = 2'b01;
      while (tx_ack[0] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      compared++; if (n_ack - a0 !== 1) begin mismatched++; $display("FAIL zero_ack got %0d want 1", n_ack - a0); end
      compared++; if (low_cnt - l0 !== 0) begin mismatched++; $display("FAIL zero_bus got %0d access cycles want 0", low_cnt - l0); end
      compared++; if (err_code !== 3'd0) begin mismatched++; $display("FAIL zero_err got %0d want 0", err_code); end
      tx_size[15:0] = 16'd9000;
      l0 = low_cnt; a0 = n_ack; k = 0;
      tx_req = 2'b01;
      while (tx_ack[0] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      tx_req = 2'b00;
      repeat (5) @(negedge clk);
      compared++; if (n_ack - a0 !== 1) begin mismatched++; $display("FAIL big_ack got %0d want 1", n_ack - a0); end
      compared++; if (low_cnt - l0 !== 0) begin mismatched++; $display("FAIL big_bus got %0d access cycles want 0", low_cnt - l0); end
      compared++; if (err_code !== 3'd4) begin mismatched++; $display("FAIL big_err got %0d want 4", err_code); end
   endtask

   task automatic test_reset_mid;
      int a0, r0, k;
      tx_size[15:0] = 16'd40;
      fsr_low_until = fsr_reads;
      k = 0;
      tx_req = 2'b01;
      while (caddr[10:0] !== 11'h22E && k < 3000) begin @(negedge clk); k++; end
      compared++; if (caddr[10:0] !== 11'h22E) begin mismatched++; $display("FAIL mid_reach_fifo got %h want 22e", caddr[10:0]); end
      repeat (7) @(negedge clk);
      a0 = n_ack; r0 = n_rxv;
      rst_n = 1'b0;
      tx_req = 2'b00;
      #1;
      compared++; if (caddr !== 12'hC00 || wr_data !== 16'h0) begin mismatched++; $display("FAIL mid_bus got %h/%h want c00/0", caddr, wr_data); end
      compared++; if (busy !== 1'b0 || tx_ack !== 2'b00 || rx_valid !== 1'b0) begin mismatched++; $display("FAIL mid_status got %b/%b/%b want 0/00/0", busy, tx_ack, rx_valid); end
      compared++; if (err_code !== 3'd0) begin mismatched++; $display("FAIL mid_err got %0d want 0", err_code); end
      compared++; if (tx_buffer_addr !== 12'h0 || rx_size !== 16'h0) begin mismatched++; $display("FAIL mid_regs got %0d/%0d want 0/0", tx_buffer_addr, rx_size); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      compared++; if (n_ack - a0 !== 0 || n_rxv - r0 !== 0) begin mismatched++; $display("FAIL mid_no_ack got %0d acks %0d strobes want 0 0", n_ack - a0, n_rxv - r0); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_idle got busy %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_tx_basic();
      test_fsr_poll();
      test_rx();
      test_zero_and_oversize();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/w5300_udp_mux.md
W5300_UDP_MUX -- requirements
Module: w5300_udp_mux

Interface
REQ-001 Parameter N_SOCK, default 2, number of UDP sockets served (1..8); socket n uses register base 10'h200 + n*10'h40.
REQ-002 Parameter BUF_AW, default 12, width of external TX/RX buffer word addresses.
REQ-003 Parameter SW = max(1, clog2(N_SOCK)), derived, socket-index width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 init_done  in  1  level, high when common and socket init are complete; block stays IDLE while low.
REQ-007 tx_req  in  N_SOCK  level request per socket; held until matching tx_ack.
REQ-008 dest_ip  in  32*N_SOCK  per-socket destination IP, slice n = [32n+31:32n].
REQ-009 dest_port  in  16*N_SOCK  per-socket destination port.
REQ-010 tx_size  in  16*N_SOCK  per-socket payload size in bytes.
REQ-011 tx_data  in  16  word at tx_buffer_addr of socket tx_sock, valid the cycle after address change.
REQ-012 tx_sock  out  SW  socket currently granted for TX.
REQ-013 tx_buffer_addr  out  BUF_AW  external TX buffer word address.
REQ-014 tx_ack  out  N_SOCK  one-cycle pulse per socket on send completion or rejection.
REQ-015 rx_data  out  16  received payload word; rx_valid  out  1  one-cycle strobe per word.
REQ-016 rx_buffer_addr  out  BUF_AW  word index within packet; rx_sock  out  SW; rx_size  out  16  byte size of current packet.
REQ-017 busy  out  1  high in every state except IDLE; err_code  out  3  sticky error.
REQ-018 op_status  in  1  bus-access done; rd_data  in  16; wr_data  out  16; caddr  out  12  {valid_n, rd, addr[9:0]}.
REQ-019 int_n  in  1  W5300 interrupt, active-low, level.

Function
REQ-020 One bus access: caddr[11]=0 with address/rd and wr_data held stable until op_status=1 is sampled; state advances that cycle; read data captured from rd_data that cycle.
REQ-021 caddr[11]=1 in IDLE, ARB and all non-access states.
REQ-022 States: IDLE, ARB, TX_FSR0, TX_FSR1, TX_CHK, DIPR0, DIPR1, DPORT, TX_FIFO, TX_INC, WRSR0, WRSR1, TX_CMD, RX_RSR0, RX_RSR1, RX_CHK, RX_HDR, RX_FIFO, RX_CMD, DONE.
REQ-023 IDLE -> ARB when init_done=1 and (int_n=0 or any tx_req=1).
REQ-024 ARB: int_n=0 selects RX on socket rx_ptr (RX priority over TX); otherwise round-robin grant of lowest requesting index at or after tx_ptr, modulo N_SOCK.
REQ-025 TX sequence: read TX_FSR (+24h,+26h) into 32 bits; TX_CHK re-polls TX_FSR while free < tx_size.
REQ-026 Then write DIPR (+14h,+16h), DPORTR (+12h), ceil(tx_size/2) words to TX_FIFOR (+2Eh), WRSR (+20h,+22h = tx_size zero-extended), CR (+02h) = 16'h0020.
REQ-027 tx_buffer_addr resets to 0 on grant and increments once per FIFO word write; final word index = ceil(tx_size/2)-1.
REQ-028 tx_size=0: no bus access; tx_ack pulses in DONE.
REQ-029 ceil(tx_size/2) > 2**BUF_AW: no bus access, err_code=3'd4, tx_ack pulses.
REQ-030 After TX completion tx_ptr = granted+1 mod N_SOCK; tx_ack[granted]=1 for exactly one cycle in DONE.
REQ-031 RX sequence: read RX_RSR (+28h,+2Ah); RX_CHK: if 0, rx_ptr advances, return to IDLE.
REQ-032 Otherwise read 4 header words from RX_FIFOR (+30h); 4th word -> rx_size; then ceil(rx_size/2) data words, each with rx_valid pulse, rx_buffer_addr 0..n-1; then CR = 16'h0040; then rx_ptr advances.
REQ-033 rx_size=0 in header: skip data reads, issue CR RECV.
REQ-034 ceil(rx_size/2) > 2**BUF_AW: words beyond the limit read and discarded (no rx_valid), err_code=3'd5.
REQ-035 tx_req deasserted mid-transfer is ignored; transfer completes.
REQ-036 All TX fields of the granted socket are latched on grant.
REQ-037 DONE -> IDLE after one cycle.

Reset
REQ-038 On rst_n low: state IDLE, caddr = 12'hC00, wr_data=0, tx_ack=0, rx_valid=0, busy=0, err_code=0, tx_ptr=rx_ptr=0, all address counters 0, tx_sock=rx_sock=0, rx_size=0.
REQ-039 Reset mid-access abandons the access immediately; no pending ack or strobe is issued after release.

Structure
REQ-040 Shared package w5300_pkg: socket register offsets, CR command codes (SEND 20h, RECV 40h), error codes, caddr field positions, FSM state encoding.
REQ-041 One sub-module w5300_rr_arbiter (N_SOCK request vector, pointer in, grant index and valid out).

Verification
REQ-042 N_SOCK=2, tx_req=2'b01, size 6, FSR=100 -> exactly DIPR,DIPR,DPORT, 3 FIFO writes, WRSR=6, CR=20h, tx_ack[0] one pulse.
REQ-043 tx_req=2'b11 held -> grants alternate 0,1,0,1.
REQ-044 FSR=4 for 3 polls then 100, size 10 -> 4 FSR read pairs, then send.
REQ-045 int_n=0 with tx_req pending, RSR=9, header size 5 -> 4 header reads, 3 rx_valid, CR=40h, then TX proceeds.
REQ-046 tx_size=0 -> tx_ack without any caddr[11]=0; size 9000, BUF_AW=12 -> err_code=4.
REQ-047 rst_n pulsed during TX_FIFO -> all REQ-038 values, no tx_ack.
